// File: rtl/regfile_mp_if.sv
// Bundle of decode/writeback signals for the multi-port register file.
// master = decode/writeback side, slave = the register file itself.
interface regfile_mp_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
);
  logic                  stall;
  logic [NRD*5-1:0]      rd_addr;
  logic [NRD*XLEN-1:0]   rd_data;
  logic [NRD-1:0]        rd_busy;
  logic                  wr0_en;
  logic [4:0]            wr0_addr;
  logic [XLEN-1:0]       wr0_data;
  logic                  wr1_en;
  logic [4:0]            wr1_addr;
  logic [XLEN-1:0]       wr1_data;
  logic                  claim_en;
  logic [4:0]            claim_addr;
  logic [NREGS-1:0]      busy_vec;

  modport master (
    output stall, rd_addr, wr0_en, wr0_addr, wr0_data,
           wr1_en, wr1_addr, wr1_data, claim_en, claim_addr,
    input  rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  stall, rd_addr, wr0_en, wr0_addr, wr0_data,
           wr1_en, wr1_addr, wr1_data, claim_en, claim_addr,
    output rd_data, rd_busy, busy_vec
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port integer register file with two write ports, optional
// write-to-read forwarding and a pending-write scoreboard.
module regfile_mp #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input  logic         clk,
  input  logic         rst,
  regfile_mp_if.slave  bus
);
  localparam int AW = $clog2(NREGS);
  localparam logic [5:0] NREGS_W = 6'(NREGS);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  logic wr0_commit;
  logic wr1_commit;
  logic claim_ok;

  // In range and not x0: the only addresses that can hold state.
  function automatic logic addr_ok(input logic [4:0] a);
    return ({1'b0, a} < NREGS_W) && (a != 5'd0);
  endfunction

  assign wr0_commit = bus.wr0_en   && !bus.stall && addr_ok(bus.wr0_addr);
  assign wr1_commit = bus.wr1_en   && !bus.stall && addr_ok(bus.wr1_addr);
  assign claim_ok   = bus.claim_en && !bus.stall && addr_ok(bus.claim_addr);

  // wr1 is applied after wr0 so it wins a same-address collision; the claim
  // is applied last because it belongs to a younger instruction.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr0_commit) begin
      regs_d[bus.wr0_addr[AW-1:0]] = bus.wr0_data;
      busy_d[bus.wr0_addr[AW-1:0]] = 1'b0;
    end
    if (wr1_commit) begin
      regs_d[bus.wr1_addr[AW-1:0]] = bus.wr1_data;
      busy_d[bus.wr1_addr[AW-1:0]] = 1'b0;
    end
    if (claim_ok) begin
      busy_d[bus.claim_addr[AW-1:0]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign bus.busy_vec = busy_q;

  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [4:0]      addr;
      logic            ok;
      logic            hit0;
      logic            hit1;
      logic [XLEN-1:0] data;
      logic            busy;

      assign addr = bus.rd_addr[5*gi +: 5];
      assign ok   = addr_ok(addr);
      // A commit already implies a valid nonzero address, so a hit implies ok.
      assign hit0 = (BYPASS != 0) && wr0_commit && (bus.wr0_addr == addr);
      assign hit1 = (BYPASS != 0) && wr1_commit && (bus.wr1_addr == addr);

      always_comb begin
        data = '0;
        busy = 1'b0;
        if (ok) begin
          if (hit1) begin
            data = bus.wr1_data;
          end else if (hit0) begin
            data = bus.wr0_data;
          end else begin
            data = regs_q[addr[AW-1:0]];
            busy = busy_q[addr[AW-1:0]];
          end
        end
      end

      assign bus.rd_data[XLEN*gi +: XLEN] = data;
      assign bus.rd_busy[gi]              = busy;
    end
  endgenerate
endmodule

// File: tb/tb_regfile_mp.sv
// Drives two register-file configurations with identical stimulus and checks
// both against an array-based model through an expected-value queue.
module tb_regfile_mp;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2)) if_a ();
  regfile_mp_if #(.XLEN(32), .NREGS(16), .NRD(3)) if_b ();

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a.slave));
  regfile_mp #(.XLEN(32), .NREGS(16), .NRD(3), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b.slave));

  typedef struct {
    int          id;
    logic [63:0] rd_a;
    logic [1:0]  rb_a;
    logic [31:0] bv_a;
    logic [95:0] rd_b;
    logic [2:0]  rb_b;
    logic [15:0] bv_b;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   txn_id  = 0;

  // Reference model: config 0 = 32 regs with forwarding, config 1 = 16 regs without.
  logic [31:0] mem [2][32];
  logic        bsy [2][32];
  int          nr  [2] = '{32, 16};
  int          byp [2] = '{1, 0};

  logic        s_r, s_st, s_e0, s_e1, s_ce;
  logic [4:0]  s_a0, s_a1, s_ca;
  logic [31:0] s_d0, s_d1;

  function automatic logic valid_nz(input int c, input logic [4:0] a);
    return (int'(a) < nr[c]) && (a != 5'd0);
  endfunction

  function automatic void mread(input int c, input logic [4:0] a,
                                output logic [31:0] d, output logic b);
    logic c0, c1;
    c0 = !s_st && s_e0 && valid_nz(c, s_a0);
    c1 = !s_st && s_e1 && valid_nz(c, s_a1);
    d = 32'h0;
    b = 1'b0;
    if (valid_nz(c, a)) begin
      if (byp[c] != 0 && c1 && s_a1 == a)      d = s_d1;
      else if (byp[c] != 0 && c0 && s_a0 == a) d = s_d0;
      else begin
        d = mem[c][a];
        b = bsy[c][a];
      end
    end
  endfunction

  function automatic void mupdate();
    for (int c = 0; c < 2; c++) begin
      if (s_r) begin
        for (int n = 0; n < 32; n++) begin
          mem[c][n] = 32'h0;
          bsy[c][n] = 1'b0;
        end
      end else if (!s_st) begin
        if (s_e0 && valid_nz(c, s_a0)) begin mem[c][s_a0] = s_d0; bsy[c][s_a0] = 1'b0; end
        if (s_e1 && valid_nz(c, s_a1)) begin mem[c][s_a1] = s_d1; bsy[c][s_a1] = 1'b0; end
        if (s_ce && valid_nz(c, s_ca)) bsy[c][s_ca] = 1'b1;
      end
    end
  endfunction

  task automatic cyc(input logic r, input logic st,
                     input logic e0, input logic [4:0] a0, input logic [31:0] d0,
                     input logic e1, input logic [4:0] a1, input logic [31:0] d1,
                     input logic ce, input logic [4:0] ca,
                     input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2);
    exp_t        e;
    logic [31:0] d;
    logic        b;
    @(posedge clk);
    #1;
    rst = r;
    s_r = r; s_st = st; s_e0 = e0; s_a0 = a0; s_d0 = d0;
    s_e1 = e1; s_a1 = a1; s_d1 = d1; s_ce = ce; s_ca = ca;
    if_a.stall = st; if_a.wr0_en = e0; if_a.wr0_addr = a0; if_a.wr0_data = d0;
    if_a.wr1_en = e1; if_a.wr1_addr = a1; if_a.wr1_data = d1;
    if_a.claim_en = ce; if_a.claim_addr = ca; if_a.rd_addr = {r1, r0};
    if_b.stall = st; if_b.wr0_en = e0; if_b.wr0_addr = a0; if_b.wr0_data = d0;
    if_b.wr1_en = e1; if_b.wr1_addr = a1; if_b.wr1_data = d1;
    if_b.claim_en = ce; if_b.claim_addr = ca; if_b.rd_addr = {r2, r1, r0};
    e.id = txn_id;
    txn_id++;
    mread(0, r0, d, b); e.rd_a[31:0]  = d; e.rb_a[0] = b;
    mread(0, r1, d, b); e.rd_a[63:32] = d; e.rb_a[1] = b;
    mread(1, r0, d, b); e.rd_b[31:0]  = d; e.rb_b[0] = b;
    mread(1, r1, d, b); e.rd_b[63:32] = d; e.rb_b[1] = b;
    mread(1, r2, d, b); e.rd_b[95:64] = d; e.rb_b[2] = b;
    for (int n = 0; n < 32; n++) e.bv_a[n] = bsy[0][n];
    for (int n = 0; n < 16; n++) e.bv_b[n] = bsy[1][n];
    q.push_back(e);
    mupdate();
  endtask

  task automatic idle(input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2);
    cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, r0, r1, r2);
  endtask

  function automatic void check(input string name, input logic [95:0] act, input logic [95:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endfunction

  // Monitor: the DUT outputs are presented every cycle; compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("rd_data_a",  {32'h0, if_a.rd_data}, {32'h0, e.rd_a});
        check("rd_busy_a",  {94'h0, if_a.rd_busy}, {94'h0, e.rb_a});
        check("busy_vec_a", {64'h0, if_a.busy_vec}, {64'h0, e.bv_a});
        check("rd_data_b",  if_b.rd_data, e.rd_b);
        check("rd_busy_b",  {93'h0, if_b.rd_busy}, {93'h0, e.rb_b});
        check("busy_vec_b", {80'h0, if_b.busy_vec}, {80'h0, e.bv_b});
        $display("[TB] txn %0d rdA=%h busyA=%b bvA=%h rdB=%h busyB=%b bvB=%h",
                 e.id, if_a.rd_data, if_a.rd_busy, if_a.busy_vec,
                 if_b.rd_data, if_b.rd_busy, if_b.busy_vec);
      end
    end
  end

  initial begin
    logic       e0, e1, ce, st, r;
    logic [4:0] a0, a1, ca, r0, r1, r2;
    int         waited;
    for (int c = 0; c < 2; c++)
      for (int n = 0; n < 32; n++) begin
        mem[c][n] = 32'h0;
        bsy[c][n] = 1'b0;
      end
    if_a.stall = 1'b0; if_a.wr0_en = 1'b0; if_a.wr0_addr = '0; if_a.wr0_data = '0;
    if_a.wr1_en = 1'b0; if_a.wr1_addr = '0; if_a.wr1_data = '0;
    if_a.claim_en = 1'b0; if_a.claim_addr = '0; if_a.rd_addr = '0;
    if_b.stall = 1'b0; if_b.wr0_en = 1'b0; if_b.wr0_addr = '0; if_b.wr0_data = '0;
    if_b.wr1_en = 1'b0; if_b.wr1_addr = '0; if_b.wr1_data = '0;
    if_b.claim_en = 1'b0; if_b.claim_addr = '0; if_b.rd_addr = '0;
    @(posedge clk);

    // Reset state, then every register on every port.
    cyc(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < 32; i++) idle(5'(i), 5'(31 - i), 5'(i));
    // x0 ignores writes.
    cyc(1'b0, 1'b0, 1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
    idle(5'd0, 5'd0, 5'd0);
    // Dual write to x5: wr1 wins.
    cyc(1'b0, 1'b0, 1'b1, 5'd5, 32'h11111111, 1'b1, 5'd5, 32'h22222222, 1'b0, 5'd0, 5'd5, 5'd5, 5'd5);
    idle(5'd5, 5'd5, 5'd5);
    // Same-cycle vs next-cycle visibility of x7.
    cyc(1'b0, 1'b0, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7, 5'd7);
    idle(5'd7, 5'd7, 5'd7);
    // Claim x9, write two cycles later, then claim+write together.
    cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd9, 5'd9);
    idle(5'd9, 5'd9, 5'd9);
    cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h1234, 1'b0, 5'd0, 5'd9, 5'd9, 5'd9);
    idle(5'd9, 5'd9, 5'd9);
    cyc(1'b0, 1'b0, 1'b1, 5'd9, 32'h77, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd9, 5'd9);
    idle(5'd9, 5'd9, 5'd9);
    // Stall blocks a write and a claim; the same stimulus unstalled applies.
    cyc(1'b0, 1'b1, 1'b1, 5'd3, 32'hFF, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd3, 5'd4, 5'd3);
    idle(5'd3, 5'd4, 5'd4);
    cyc(1'b0, 1'b0, 1'b1, 5'd3, 32'hFF, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd3, 5'd4, 5'd3);
    idle(5'd3, 5'd4, 5'd4);
    // x20 is out of range for the 16-register file.
    cyc(1'b0, 1'b0, 1'b1, 5'd20, 32'h55, 1'b0, 5'd0, 32'h0, 1'b1, 5'd20, 5'd20, 5'd20, 5'd20);
    idle(5'd20, 5'd20, 5'd20);
    // Reset with pending busy bits.
    cyc(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd9, 5'd3);
    idle(5'd4, 5'd9, 5'd3);

    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 49) == 0);
      st = ($urandom_range(0, 7) == 0);
      e0 = !r && ($urandom_range(0, 1) == 1);
      e1 = !r && ($urandom_range(0, 2) == 0);
      ce = !r && ($urandom_range(0, 1) == 1);
      a0 = 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 3) == 0) ? a0 : 5'($urandom_range(0, 31));
      ca = ($urandom_range(0, 3) == 0) ? a0 : 5'($urandom_range(0, 31));
      r0 = ($urandom_range(0, 2) == 0) ? a0 : 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 2) == 0) ? a1 : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 2) == 0) ? ca : 5'($urandom_range(0, 31));
      cyc(r, st, e0, a0, $urandom, e1, a1, $urandom, ce, ca, r0, r1, r2);
    end

    waited = 0;
    while (q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL drain: %0d expected entries left, required 0", q.size());
    end
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the RISC-V core, the successor of the 32x32 two-read/one-write file. It adds a configurable register count (RV32I/RV32E), a configurable number of read ports, two write ports (ALU writeback and load writeback), optional same-cycle write-to-read bypass, and a pending-write scoreboard. It sits between decode (reads, claims) and writeback (writes, clears).

## Interface
- XLEN, 32, data width
- NREGS, 32, register count; only 16 or 32 are legal. AW = $clog2(NREGS).
- NRD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = no forwarding
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stall  in  1  freezes all state updates (writes, claims, clears)
- rd_addr  in  NRD*5  read addresses; port i uses bits [5i+4:5i]
- rd_data  out  NRD*XLEN  read data; port i uses bits [XLEN*i+XLEN-1:XLEN*i]
- rd_busy  out  NRD  read port i targets a register with a pending write
- wr0_en, wr0_addr[4:0], wr0_data[XLEN-1:0]  in  write port 0 (ALU)
- wr1_en, wr1_addr[4:0], wr1_data[XLEN-1:0]  in  write port 1 (load)
- claim_en, claim_addr[4:0]  in  marks a destination as pending (issue)
- busy_vec  out  NREGS  registered scoreboard, bit n = register n pending

## Operation
- Register x0:
  - Reads always return 0.
  - Writes to x0 are ignored.
  - busy bit 0 is always 0.
- Out-of-range address (addr >= NREGS):
  - Reads return 0 with rd_busy 0.
  - Writes and claims are ignored.
- Writes commit on posedge clk when wrN_en=1, stall=0 and the address is valid and nonzero.
- Both ports write the same address in one cycle: wr1 wins.
- Reads are combinational:
  - BYPASS=1: if a committing write targets rd_addr this cycle, rd_data returns that write's data (wr1 over wr0). Otherwise it returns the stored value.
  - BYPASS=0: rd_data always returns the stored value.
- Scoreboard update per cycle when stall=0:
  - A write to a valid address n clears busy[n].
  - claim_en to a valid address m sets busy[m].
  - Claim and write to the same address in the same cycle: busy stays 1 (the claim is younger).
- rd_busy[i]:
  - BYPASS=1: busy[rd_addr_i] AND NOT (committing write to rd_addr_i this cycle).
  - BYPASS=0: busy[rd_addr_i] alone.
- stall=1: registers and busy_vec hold, and write enables are ignored. Reads still return stored values; with BYPASS=1 no forwarding happens, because no write commits.

## Timing
- Reset (rst=1 at posedge):
  - All registers go to 0 and busy_vec goes to 0.
  - Reset takes priority over stall, writes and claims.
  - During reset cycles, rd_data reflects the reset contents after the first edge.
- Read latency is 0 cycles (combinational from rd_addr and from write ports when BYPASS=1).
- A write is visible to reads:
  - BYPASS=1: in the same cycle.
  - BYPASS=0: from the next cycle.
- busy_vec changes only at posedge. A claim at edge k is visible in busy_vec after edge k.
- Reset asserted mid-operation discards all pending busy bits and data in one cycle.

## Test plan
- Reset, then read all registers on every port -> all rd_data 0 and busy_vec 0. Write x0=0xDEADBEEF -> x0 still reads 0.
- wr0 x5=0x11111111 and wr1 x5=0x22222222 in the same cycle (BYPASS=1) -> port 0 reads 0x22222222 in that cycle, and x5=0x22222222 afterwards.
- BYPASS=0: wr0 x7=0xA5A5A5A5 -> read x7 returns the old value in the same cycle and 0xA5A5A5A5 on the next cycle.
- Claim x9, then wr1 x9=0x1234 two cycles later:
  - busy_vec[9]=1 for 2 cycles.
  - rd_busy is 0 in the write cycle (BYPASS=1).
  - busy_vec[9]=0 after the write.
  - Claim and write x9 in the same cycle -> busy_vec[9] stays 1.
- stall=1 with wr0 x3=0xFF and claim x4 -> no change to x3 or busy_vec[4]. The same stimulus with stall=0 -> both update.
- NREGS=16: write x20=0x55 and claim x20 -> ignored; read x20 returns 0 with rd_busy 0. Also assert rst while busy_vec is nonzero -> busy_vec 0 next cycle.
